// File: rtl/im_loader.sv
// im_loader: boot-time writer for the byte-addressed instruction memory.
// Parses MAGIC/LEN/payload/CSUM frames and holds the CPU until a clean load.
module im_loader #(
    parameter int          MEM_BYTES = 32,
    parameter logic [7:0]  MAGIC     = 8'hA5
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic [7:0]  RX_DATA,
    input  logic        RX_VALID,
    output logic        RX_READY,
    output logic        MEM_WE,
    output logic [63:0] MEM_ADDR,
    output logic [7:0]  MEM_WDATA,
    output logic        CPU_HOLD,
    output logic        LOAD_DONE,
    output logic        LOAD_ERR,
    output logic [1:0]  ERR_CODE
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAGIC,
        S_LEN_HI,
        S_LEN_LO,
        S_LOAD,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [15:0] MAX_LEN = 16'(MEM_BYTES);

    localparam logic [1:0] E_NONE  = 2'd0;
    localparam logic [1:0] E_MAGIC = 2'd1;
    localparam logic [1:0] E_LEN   = 2'd2;
    localparam logic [1:0] E_CSUM  = 2'd3;

    state_t      state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [15:0] idx_q, idx_d;
    logic [7:0]  csum_q, csum_d;
    logic        we_q, we_d;
    logic [63:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        hold_q, hold_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [1:0]  code_q, code_d;

    logic        accept;
    logic [15:0] len_new;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            csum_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= E_NONE;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            csum_q  <= csum_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    always_comb begin
        RX_READY = 1'b0;
        unique case (state_q)
            S_MAGIC, S_LEN_HI, S_LEN_LO,
            S_LOAD, S_CHECK: RX_READY = 1'b1;
            default:         RX_READY = 1'b0;
        endcase
    end

    assign accept  = RX_VALID && RX_READY;
    assign len_new = {len_q[15:8], RX_DATA};

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        csum_d  = csum_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        hold_d  = hold_q;
        done_d  = done_q;
        err_d   = err_q;
        code_d  = code_q;

        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (START) begin
                    state_d = S_MAGIC;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    code_d  = E_NONE;
                    hold_d  = 1'b1;
                    idx_d   = '0;
                    csum_d  = '0;
                end
            end
            S_MAGIC: begin
                if (accept) begin
                    if (RX_DATA == MAGIC) begin
                        state_d = S_LEN_HI;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                        code_d  = E_MAGIC;
                    end
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    len_d   = {RX_DATA, len_q[7:0]};
                    state_d = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    len_d = len_new;
                    if (len_new == '0 || len_new > MAX_LEN) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                        code_d  = E_LEN;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (accept) begin
                    we_d    = 1'b1;
                    addr_d  = 64'(idx_q);
                    wdata_d = RX_DATA;
                    csum_d  = csum_q + RX_DATA;
                    idx_d   = idx_q + 16'd1;
                    if (idx_q == len_q - 16'd1) begin
                        state_d = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (accept) begin
                    if (RX_DATA == csum_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                        code_d  = E_CSUM;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign MEM_WE    = we_q;
    assign MEM_ADDR  = addr_q;
    assign MEM_WDATA = wdata_q;
    assign CPU_HOLD  = hold_q;
    assign LOAD_DONE = done_q;
    assign LOAD_ERR  = err_q;
    assign ERR_CODE  = code_q;

endmodule
